// File: rtl/pwm_pkg.sv
// Shared definitions for the duty-cycle PWM link (generator and capture sides).
package pwm_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    localparam int DUTY_W      = 8;
    localparam int DUTY_MAX    = 255;
    localparam int STEP_DEF    = 4;
    localparam int CW_DEF      = 21;
    localparam int TIMEOUT_DEF = 1048575;
    localparam int SYNC_DEF    = 2;

    // Unit counter runs to 256 so "more than full scale" stays visible until clamped here.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [8:0] units);
        return (units > 9'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : units[DUTY_W-1:0];
    endfunction
endpackage

// File: rtl/pwm_sync_edge.sv
// Metastability synchroniser for the PWM pin plus registered edge detection.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic rise,
    output logic fall,
    output logic level
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_d_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~s_d_q;
    assign fall  = ~level & s_d_q;
endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period between rising edges, decodes duty,
// and reports a stuck line after TIMEOUT cycles without a rising edge.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int STEP        = STEP_DEF,
    parameter int CW          = CW_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CW-1:0]     period,
    output logic              duty_valid,
    output logic              stuck,
    output logic              level
);
    localparam int            SW        = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);
    localparam logic [SW-1:0] STEP_INIT = (STEP == 1) ? SW'(0) : SW'(1);
    localparam logic [8:0]    UNIT_INIT = (STEP == 1) ? 9'd1 : 9'd0;
    localparam logic [8:0]    UNIT_SAT  = 9'd256;
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    logic rise, fall, lvl;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall),
        .level  (lvl)
    );

    state_e            state_q, state_d;
    logic [CW-1:0]     per_cnt_q, per_cnt_d;
    logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [SW-1:0]     step_cnt_q, step_cnt_d;
    logic [8:0]        unit_cnt_q, unit_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CW-1:0]     period_q, period_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;
    logic              restart, report, timeout;

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        idle_cnt_d = idle_cnt_q;
        step_cnt_d = step_cnt_q;
        unit_cnt_d = unit_cnt_q;
        duty_d     = duty_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        restart    = 1'b0;
        report     = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            IDLE: begin
                per_cnt_d = '0;
                if (rise) begin
                    restart    = 1'b1;
                    stuck_d    = 1'b0;
                    idle_cnt_d = '0;
                end else if (!stuck_q) begin
                    // Once stuck is reported, stay quiet until the line moves again.
                    if (idle_cnt_q >= TO_LAST) timeout = 1'b1;
                    else                       idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (per_cnt_q >= TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CW'(1);
                    if (fall) begin
                        state_d = LOW;
                    end else if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = '0;
                        if (unit_cnt_q != UNIT_SAT) unit_cnt_d = unit_cnt_q + 9'd1;
                    end else begin
                        step_cnt_d = step_cnt_q + SW'(1);
                    end
                end
            end
            LOW: begin
                // A rise coinciding with the timeout threshold is a valid edge.
                if (rise) begin
                    report  = 1'b1;
                    restart = 1'b1;
                end else if (per_cnt_q >= TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (report) begin
            duty_d   = sat_duty(unit_cnt_q);
            period_d = per_cnt_q;
            valid_d  = 1'b1;
        end
        // The rising cycle is already the first high cycle of the new period.
        if (restart) begin
            state_d    = HIGH;
            per_cnt_d  = CW'(1);
            step_cnt_d = STEP_INIT;
            unit_cnt_d = UNIT_INIT;
        end
        if (timeout) begin
            state_d    = IDLE;
            per_cnt_d  = '0;
            idle_cnt_d = '0;
            stuck_d    = 1'b1;
            duty_d     = lvl ? DUTY_W'(DUTY_MAX) : '0;
            period_d   = '0;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            idle_cnt_q <= '0;
            step_cnt_q <= '0;
            unit_cnt_q <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            step_cnt_q <= step_cnt_d;
            unit_cnt_q <= unit_cnt_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
        end
    end

    assign duty       = duty_q;
    assign period     = period_q;
    assign duty_valid = valid_q & ~reset;
    assign stuck      = stuck_q;
    assign level      = lvl;
endmodule
